// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-op encodings, 2-bit predictor counter constants and the counter update helper.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    OpBeq  = 3'b000,
    OpBne  = 3'b001,
    OpBlt  = 3'b100,
    OpBge  = 3'b101,
    OpBltu = 3'b110,
    OpBgeu = 3'b111
  } branch_op_e;

  localparam logic [1:0] CntReset = 2'b01;  // weakly not-taken
  localparam logic [1:0] CntMax   = 2'b11;
  localparam logic [1:0] CntMin   = 2'b00;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != CntMax) begin
      nxt = cnt + 2'd1;
    end else if (!taken && cnt != CntMin) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result bus of the branch resolve unit; master drives requests and consumes results.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      branch_op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_mispredict;
  logic            out_illegal;

  modport master (
    output in_valid, branch_op, rs1, rs2, pc, imm, pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_redirect_pc, out_mispredict,
           out_illegal
  );

  modport slave (
    input  in_valid, branch_op, rs1, rs2, pc, imm, pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_redirect_pc, out_mispredict,
           out_illegal
  );

endinterface

// File: rtl/branch_resolve_unit_branch_cmp.sv
// Combinational RV conditional-branch comparator; funct3 010/011 are reported illegal, not taken.
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      branch_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq, lt, ltu;

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (branch_op)
      OpBeq:   taken = eq;
      OpBne:   taken = !eq;
      OpBlt:   taken = lt;
      OpBge:   taken = !lt;
      OpBltu:  taken = ltu;
      OpBgeu:  taken = !ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolver with a 2-bit counter BHT; define BRU_PERF_CNT_EN to add
// saturating branch/mispredict performance counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  branch_resolve_unit_if.slave   bus,
  input  logic [XLEN-1:0]        lookup_pc,
  output logic                   lookup_taken
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
`endif
);

  logic            taken, illegal, accept, valid_d;
  logic [XLEN-1:0] target, seq_pc;
  logic [BHT_IDX_W-1:0] lookup_idx, upd_idx;

  logic            valid_q, taken_q, mis_q, illegal_q;
  logic [XLEN-1:0] target_q, redirect_q;
  logic [1:0]      bht_q [BHT_DEPTH];

  branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .branch_op(bus.branch_op),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .taken    (taken),
    .illegal  (illegal)
  );

  assign target       = bus.pc + bus.imm;
  assign seq_pc       = bus.pc + XLEN'(4);
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  // Index is PC word address modulo table depth, same for lookup and training.
  assign lookup_idx   = BHT_IDX_W'(lookup_pc >> 2);
  assign upd_idx      = BHT_IDX_W'(bus.pc >> 2);
  assign lookup_taken = bht_q[lookup_idx][1];

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      mis_q      <= 1'b0;
      illegal_q  <= 1'b0;
      target_q   <= '0;
      redirect_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        taken_q    <= taken;
        mis_q      <= taken ^ bus.pred_taken;
        illegal_q  <= illegal;
        target_q   <= target;
        redirect_q <= taken ? target : seq_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CntReset;
      end
    end else if (accept && !illegal) begin
      bht_q[upd_idx] <= cnt_next(bht_q[upd_idx], taken);
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_taken       = taken_q;
  assign bus.out_target      = target_q;
  assign bus.out_redirect_pc = redirect_q;
  assign bus.out_mispredict  = mis_q;
  assign bus.out_illegal     = illegal_q;

`ifdef BRU_PERF_CNT_EN
  logic        retire;
  logic [31:0] perf_br_q, perf_mis_q;

  // Flush kills the handshake, so flushed results are never counted.
  assign retire = valid_q && bus.out_ready && !flush && !illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else if (retire) begin
      if (perf_br_q != '1) perf_br_q <= perf_br_q + 32'd1;
      if (mis_q && perf_mis_q != '1) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`endif

endmodule
